a1339_spi_scheduler: RTL

//  Shares one 20-bit spi_master between NUM_REQ requesters, e.g. per-sensor A1339 pollers
//  and a configuration writer. Each transaction runs two SPI frames: command, then repeat.
//  The A1339 answers a command in the following frame, so frame 2 carries the response.
//  The block checks the 4-bit CRC, returns a 16-bit payload to the requester and routes
//  the slave select of the spi_master to the granted sensor.

---
 rtl/a1339_spi_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/a1339_spi_scheduler.sv
// Round-robin scheduler that shares one 20-bit spi_master between several A1339 requesters.
// Each grant runs a command frame and a repeat frame, then CRC-checks the frame-2 response.
module a1339_spi_scheduler #(
  parameter int  NUM_REQ        = 4,
  parameter int  FRAME_BITS     = 20,
  parameter int  TIMEOUT_CYCLES = 1023,
  localparam int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*FRAME_BITS-1:0] cmd_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          rsp_valid_o,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic [15:0]                   rsp_data_o,
  output logic                          rsp_crc_ok_o,
  output logic                          rsp_timeout_o,
  output logic [FRAME_BITS-1:0]         spi_di_o,
  output logic                          spi_wren_o,
  input  logic                          spi_do_valid_i,
  input  logic [FRAME_BITS-1:0]         spi_do_i,
  input  logic                          spi_ssel_i,
  output logic [NUM_REQ-1:0]            ss_n_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND1, S_WAIT1, S_SEND2, S_WAIT2, S_DONE
  } state_t;

  state_t                 r_state;
  logic [ID_W-1:0]        r_ptr;
  logic [ID_W-1:0]        r_gnt_id;
  logic [NUM_REQ-1:0]     r_gnt;
  logic [CNT_W-1:0]       r_cnt;
  logic [FRAME_BITS-1:0]  r_di;
  logic [FRAME_BITS-1:0]  r_rx;
  logic                   r_wren;
  logic                   r_to;
  logic                   r_rsp_valid;
  logic [ID_W-1:0]        r_rsp_id;
  logic [15:0]            r_rsp_data;
  logic                   r_rsp_crc_ok;
  logic                   r_rsp_to;

  logic                   w_any;
  logic [ID_W-1:0]        w_sel;
  logic [FRAME_BITS-1:0]  w_cmd;
  logic [ID_W-1:0]        w_next_ptr;
  logic                   w_crc_ok;

  // A1339 CRC-4: seed 1111, payload shifted MSB first.
  function automatic logic [3:0] crc4(input logic [15:0] d);
    logic [3:0] c;
    logic       inv;
    c = 4'hF;
    for (int i = 15; i >= 0; i--) begin
      inv = d[i] ^ c[3];
      c   = {c[2], c[1], c[0] ^ inv, inv};
    end
    return c;
  endfunction

  // NOTE: every variable gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    int idx;
    w_any = 1'b0;
    w_sel = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_any && req_i[ID_W'(idx)]) begin
        w_any = 1'b1;
        w_sel = ID_W'(idx);
      end
    end
  end

  assign w_cmd      = cmd_i[w_sel*FRAME_BITS +: FRAME_BITS];
  assign w_next_ptr = (r_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;
  assign w_crc_ok   = (crc4(r_rx[FRAME_BITS-1 -: 16]) == r_rx[3:0]);

  // NOTE: non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_gnt_id     <= '0;
      r_gnt        <= '0;
      r_cnt        <= '0;
      r_di         <= '0;
      r_rx         <= '0;
      r_wren       <= 1'b0;
      r_to         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_data   <= '0;
      r_rsp_crc_ok <= 1'b0;
      r_rsp_to     <= 1'b0;
    end else begin
      r_wren      <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt    <= NUM_REQ'(1) << w_sel;
            r_gnt_id <= w_sel;
            r_di     <= w_cmd;
            r_wren   <= 1'b1;
            r_state  <= S_SEND1;
          end
        end
        S_SEND1: begin
          r_cnt   <= '0;
          r_to    <= 1'b0;
          r_state <= S_WAIT1;
        end
        S_WAIT1: begin
          if (spi_do_valid_i) begin
            r_wren  <= 1'b1;
            r_state <= S_SEND2;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              r_to    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_SEND2: begin
          r_cnt   <= '0;
          r_state <= S_WAIT2;
        end
        S_WAIT2: begin
          if (spi_do_valid_i) begin
            r_rx    <= spi_do_i;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              r_to    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_rsp_valid  <= 1'b1;
          r_rsp_id     <= r_gnt_id;
          r_rsp_data   <= r_to ? 16'h0000 : r_rx[FRAME_BITS-1 -: 16];
          r_rsp_crc_ok <= r_to ? 1'b0 : w_crc_ok;
          r_rsp_to     <= r_to;
          r_gnt        <= '0;
          r_ptr        <= w_next_ptr;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Only the granted sensor follows the master's select; everyone else stays deselected.
  assign ss_n_o        = ~r_gnt | {NUM_REQ{spi_ssel_i}};
  assign gnt_o         = r_gnt;
  assign spi_di_o      = r_di;
  assign spi_wren_o    = r_wren;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_id_o      = r_rsp_id;
  assign rsp_data_o    = r_rsp_data;
  assign rsp_crc_ok_o  = r_rsp_crc_ok;
  assign rsp_timeout_o = r_rsp_to;

endmodule
